apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one APB bus between NUM_REQ requesters (CPU/DMA-style ports) using round-robin arbitration.
//  Sequences the granted request through the APB IDLE->SETUP->ACCESS protocol and decodes psel for two slaves.
//  Returns read data and error status to the winning requester.
//  Sits between the requesters and the APB bridge/slave side of the bus.
// PARAMETERS
//  NUM_REQ   2    number of requester ports (2..8)
//  D_WIDTH   32   address and data width
//  SEL_BIT   31   paddr bit that selects the slave: 0 -> psel[0], 1 -> psel[1]
//  TIMEOUT   16   max ACCESS cycles without pready before abort; 0 disables timeout
// PORTS
//  clk        in   1               clock
//  rstn       in   1               reset, synchronous, active-low
//  req_valid  in   NUM_REQ         per-requester transfer request; held until req_ready
//  req_ready  out  NUM_REQ         one-cycle accept pulse to the granted requester
//  req_write  in   NUM_REQ         1 = write, 0 = read
//  req_addr   in   NUM_REQ*D_WIDTH packed addresses; requester i at [i*D_WIDTH +: D_WIDTH]
//  req_wdata  in   NUM_REQ*D_WIDTH packed write data
//  req_strb   in   NUM_REQ*4       packed byte strobes
//  req_prot   in   NUM_REQ*3       packed protection attributes
//  rsp_valid  out  NUM_REQ         one-cycle completion pulse to the owning requester
//  rsp_rdata  out  D_WIDTH         read data; valid with rsp_valid
//  rsp_err    out  1               pslverr or timeout; valid with rsp_valid
//  psel       out  2               slave selects, one-hot or zero
//  penable    out  1               APB enable
//  paddr      out  D_WIDTH         APB address
//  pwrite     out  1               APB direction
//  pwdata     out  D_WIDTH         APB write data
//  pstrb      out  4               APB strobes; forced 0 on reads
//  pprot      out  3               APB protection
//  pready     in   1               slave ready
//  prdata     in   D_WIDTH         slave read data
//  pslverr    in   1               slave error
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. FSM enters IDLE. RR pointer is set so requester 0 has top priority.
//   - Reset during SETUP/ACCESS drops psel/penable on the next edge. No rsp_valid is issued for the aborted transfer.
//  FSM:
//   - IDLE: if any req_valid, pick winner g by RR starting at last_grant+1 (mod NUM_REQ).
//     Assert req_ready[g] combinationally this cycle. Register addr/wdata/strb/prot/write and g.
//     Go to SETUP.
//   - SETUP: psel[paddr[SEL_BIT]]=1, penable=0; all APB outputs are stable from registers.
//     Always go to ACCESS after one cycle.
//   - ACCESS: penable=1, psel held, APB outputs unchanged.
//     On pready: capture prdata (reads only; writes return 0) and pslverr; go to IDLE.
//     Next cycle: rsp_valid[g]=1 for exactly one cycle with rsp_rdata/rsp_err.
//   - Timeout: cycle counter counts ACCESS cycles with pready=0. At TIMEOUT, go to IDLE with psel=penable=0.
//     Next cycle: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
//  Arbitration and timing:
//   - last_grant updates only on an accept. A requester cannot be starved: max wait is NUM_REQ-1 transfers.
//   - Latency: accept at T, SETUP at T+1, ACCESS at T+2. With zero-wait pready, rsp_valid at T+3 and next accept at T+3.
//   - req_valid deasserting before req_ready is legal; the port is simply not granted.
//   - rsp_valid for a transfer and req_ready for the next may coincide in the same cycle.
//  Widths and encoding:
//   - pstrb = req_strb on writes, 4'b0 on reads. pwdata is passed unmasked.
//   - Counter width is $clog2(TIMEOUT+1).
//   - psel is never two-hot. psel/penable are never 1 outside SETUP/ACCESS.
// TESTING
//  1. Single write: req0 write addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF.
//     -> psel=2'b01, penable 0 then 1, pstrb=F; rsp_valid[0] at T+3, rsp_err=0.
//  2. Read, 2 wait states: req1 read addr 0x8000_0004; slave drives pready low 2 cycles, then prdata=0x1234_5678.
//     -> psel=2'b10, pstrb=0; rsp_rdata=0x1234_5678 on rsp_valid[1].
//  3. Contention: req0 and req1 held valid continuously.
//     -> grants alternate 0,1,0,1; each accept spaced 3 cycles with zero-wait slave.
//  4. Slave error: pslverr=1 with pready on a write.
//     -> rsp_err=1 with rsp_valid; FSM returns to IDLE.
//  5. Timeout: TIMEOUT=4, pready held 0.
//     -> after 4 ACCESS cycles psel=penable=0; rsp_valid with rsp_err=1, rsp_rdata=0.
//  6. Reset mid-ACCESS: rstn=0 for 1 cycle during ACCESS.
//     -> all outputs 0 next edge, no rsp_valid; requester 0 wins the next contention.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters.
// It runs each granted transfer through SETUP/ACCESS and returns rdata/err to its owner.
module apb_master_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned SEL_BIT = 31,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*D_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*D_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*4-1:0]         req_strb,
  input  logic [NUM_REQ*3-1:0]         req_prot,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [D_WIDTH-1:0]           rsp_rdata,
  output logic                         rsp_err,
  output logic [1:0]                   psel,
  output logic                         penable,
  output logic [D_WIDTH-1:0]           paddr,
  output logic                         pwrite,
  output logic [D_WIDTH-1:0]           pwdata,
  output logic [3:0]                   pstrb,
  output logic [2:0]                   pprot,
  input  logic                         pready,
  input  logic [D_WIDTH-1:0]           prdata,
  input  logic                         pslverr
);

  localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      owner_q, owner_d;
  logic [D_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]         strb_q, strb_d;
  logic [2:0]         prot_q, prot_d;
  logic               write_q, write_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               hi_found, lo_found, any_req;
  logic [GW-1:0]      hi_idx, lo_idx, winner;
  logic               timeout_hit;
  logic               bus_active;

  // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (req_valid[j-1]) begin
        if (GW'(j - 1) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(j - 1);
        end else begin
          lo_found = 1'b1;
          lo_idx   = GW'(j - 1);
        end
      end
    end
    any_req = hi_found | lo_found;
    winner  = hi_found ? hi_idx : lo_idx;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    prot_d       = prot_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rdata_d      = '0;
    err_d        = 1'b0;
    req_ready    = '0;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          req_ready[winner] = 1'b1;
          last_grant_d      = winner;
          owner_d           = winner;
          addr_d            = req_addr[winner*D_WIDTH +: D_WIDTH];
          wdata_d           = req_wdata[winner*D_WIDTH +: D_WIDTH];
          write_d           = req_write[winner];
          strb_d            = req_write[winner] ? req_strb[winner*4 +: 4] : 4'b0;
          prot_d            = req_prot[winner*3 +: 3];
          state_d           = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          rsp_valid_d[owner_q] = 1'b1;
          rdata_d              = write_q ? '0 : prdata;
          err_d                = pslverr;
          state_d              = StIdle;
        end else if (timeout_hit) begin
          rsp_valid_d[owner_q] = 1'b1;
          err_d                = 1'b1;
          state_d              = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // No accept may be signalled while reset is being applied.
    if (!rstn) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= GW'(NUM_REQ - 1);
      owner_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      prot_q       <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      prot_q       <= prot_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus_active = (state_q == StSetup) || (state_q == StAccess);
  assign psel[0]    = bus_active & ~addr_q[SEL_BIT];
  assign psel[1]    = bus_active &  addr_q[SEL_BIT];
  assign penable    = (state_q == StAccess);
  assign paddr      = addr_q;
  assign pwrite     = write_q;
  assign pwdata     = wdata_q;
  assign pstrb      = strb_q;
  assign pprot      = prot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios then random traffic, checked against a
// transaction-level timing model (accept at T, setup T+1, access from T+2).
module tb_apb_master_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int SB = 31;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [N*DW-1:0]   req_addr, req_wdata;
  logic [N*4-1:0]    req_strb;
  logic [N*3-1:0]    req_prot;
  logic [DW-1:0]     rsp_rdata, paddr, pwdata, prdata;
  logic              rsp_err, penable, pwrite, pready, pslverr;
  logic [1:0]        psel;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;

  apb_master_arbiter #(
    .NUM_REQ (N),
    .D_WIDTH (DW),
    .SEL_BIT (SB),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Requester-side state and the slave behaviour planned for each pending request.
  bit          rv[N];
  bit          rw[N];
  logic [31:0] ra[N], rd[N], rrd[N];
  logic [3:0]  rs[N];
  logic [2:0]  rp[N];
  int          rwt[N];
  bit          re[N];
  int          next_req[N];
  bit          auto_en[N];
  int          gap_max = 0;
  bit          drop_en = 1'b0;
  bit          zero_wait = 1'b0;

  // Transfer-level model.
  int          cyc = 0;
  int          rr_last, free_cyc, acc_cyc, rsp_cyc, rsp_owner;
  bit          has_tr, rsp_e;
  logic [31:0] rsp_data;
  bit          t_w, t_err;
  logic [31:0] t_a, t_d, t_rd;
  logic [3:0]  t_s;
  logic [2:0]  t_p;
  int          t_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input int wt, input bit e,
                         input logic [31:0] prd);
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rd[i] = d; rs[i] = s; rp[i] = p;
    rwt[i] = wt; re[i] = e; rrd[i] = prd;
  endtask

  task automatic gen_rand(input int i);
    int wt;
    bit e;
    wt = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(0, 3));
    e  = ($urandom_range(0, 7) == 0);
    if (zero_wait) begin
      wt = 0;
      e  = 1'b0;
    end
    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), wt, e, $urandom);
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (rr_last + k) % N;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    rr_last  = N - 1;
    has_tr   = 1'b0;
    free_cyc = cyc;
    rsp_cyc  = -1;
    for (int i = 0; i < N; i++) begin
      rv[i]       = 1'b0;
      next_req[i] = cyc;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rv[i];
      req_write[i]          = rw[i];
      req_addr[i*DW +: DW]  = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
      req_strb[i*4 +: 4]    = rs[i];
      req_prot[i*3 +: 3]    = rp[i];
    end
    if (has_tr && cyc >= acc_cyc + 2 && cyc < free_cyc) begin
      pready  = (cyc - acc_cyc - 2) >= t_wait;
      prdata  = pready ? t_rd : $urandom;
      pslverr = pready ? t_err : 1'b0;
    end else begin
      // Outside ACCESS the slave signals are noise the arbiter must ignore.
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; applies reset for n edges and checks the cleared outputs.
  task automatic reset_pulse(input int n);
    rstn      = 1'b0;
    req_valid = '0;
    pready    = 1'b0;
    repeat (n) @(posedge clk);
    #1 rstn = 1'b1;
    cyc += n;
    model_reset();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwrite", 64'(pwrite), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_pstrb", 64'(pstrb), 64'(0));
    check("rst_pprot", 64'(pprot), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step();
    int          g;
    bit          in_tr;
    logic [N-1:0] ev;
    logic [1:0]  ep;
    for (int i = 0; i < N; i++)
      if (auto_en[i] && !rv[i] && cyc >= next_req[i]) gen_rand(i);
    drive_inputs();
    g     = (cyc >= free_cyc) ? pick() : -1;
    in_tr = has_tr && cyc > acc_cyc && cyc < free_cyc;
    @(negedge clk);
    ev = '0;
    if (g >= 0) ev[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(ev));
    if (in_tr) begin
      ep = t_a[SB] ? 2'b10 : 2'b01;
      check("psel", 64'(psel), 64'(ep));
      check("penable", 64'(penable), 64'(cyc >= acc_cyc + 2));
      check("paddr", 64'(paddr), 64'(t_a));
      check("pwrite", 64'(pwrite), 64'(t_w));
      check("pwdata", 64'(pwdata), 64'(t_d));
      check("pstrb", 64'(pstrb), 64'(t_w ? t_s : 4'b0));
      check("pprot", 64'(pprot), 64'(t_p));
    end else begin
      check("psel_idle", 64'(psel), 64'(0));
      check("penable_idle", 64'(penable), 64'(0));
    end
    ev = '0;
    if (cyc == rsp_cyc) ev[rsp_owner] = 1'b1;
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (cyc == rsp_cyc) begin
      check("rsp_rdata", 64'(rsp_rdata), 64'(rsp_data));
      check("rsp_err", 64'(rsp_err), 64'(rsp_e));
    end
    if (g >= 0) begin
      has_tr  = 1'b1;
      acc_cyc = cyc;
      rr_last = g;
      t_w = rw[g]; t_a = ra[g]; t_d = rd[g]; t_s = rs[g]; t_p = rp[g];
      t_wait = rwt[g]; t_err = re[g]; t_rd = rrd[g];
      if (t_wait < TO) begin
        rsp_cyc  = cyc + 3 + t_wait;
        rsp_e    = t_err;
        rsp_data = t_w ? 32'h0 : t_rd;
      end else begin
        rsp_cyc  = cyc + 2 + TO;
        rsp_e    = 1'b1;
        rsp_data = 32'h0;
      end
      rsp_owner   = g;
      free_cyc    = rsp_cyc;
      rv[g]       = 1'b0;
      next_req[g] = cyc + 1 + int'($urandom_range(0, gap_max));
    end
    if (drop_en) begin
      for (int i = 0; i < N; i++) begin
        if (i != g && rv[i] && $urandom_range(0, 15) == 0) begin
          rv[i]       = 1'b0;
          next_req[i] = cyc + 1 + int'($urandom_range(0, gap_max));
        end
      end
    end
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; rrd[i] = '0;
      rs[i] = '0; rp[i] = '0; rwt[i] = 0; re[i] = 1'b0; auto_en[i] = 1'b0;
    end

    reset_pulse(3);

    // Single zero-wait write from requester 0.
    set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h5555_AAAA);
    run(6);

    // Read from requester 1 on slave 1 with two wait states.
    set_req(1, 1'b0, 32'h8000_0004, 32'h0BAD_F00D, 4'hC, 3'd1, 2, 1'b0, 32'h1234_5678);
    run(8);

    // Continuous contention between requesters 0 and 1 with a zero-wait slave.
    zero_wait  = 1'b1;
    auto_en[0] = 1'b1;
    auto_en[1] = 1'b1;
    run(14);
    auto_en[0] = 1'b0;
    auto_en[1] = 1'b0;
    zero_wait  = 1'b0;
    run(5);

    // Slave error on a write.
    set_req(1, 1'b1, 32'h0000_0100, 32'hCAFE_0001, 4'h3, 3'd0, 0, 1'b1, 32'h0);
    run(5);

    // Timeout: slave never answers.
    set_req(2, 1'b0, 32'h8000_0100, 32'h0, 4'hF, 3'd7, 100, 1'b0, 32'hFFFF_FFFF);
    run(9);

    // Reset pulled during ACCESS; the aborted transfer gets no response.
    set_req(2, 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 3'd0, 5, 1'b0, 32'h0);
    run(3);
    reset_pulse(1);
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'h1, 3'd3, 0, 1'b0, 32'h0A0B_0C0D);
    set_req(1, 1'b1, 32'h8000_0040, 32'h7777_8888, 4'h6, 3'd5, 1, 1'b0, 32'h0);
    run(10);

    // Random traffic from all requesters with gaps, drops, errors and timeouts.
    gap_max = 3;
    drop_en = 1'b1;
    for (int i = 0; i < N; i++) auto_en[i] = 1'b1;
    run(600);
    for (int i = 0; i < N; i++) auto_en[i] = 1'b0;
    drop_en = 1'b0;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    run(12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
